// File: rtl/dram_read_arbiter.sv
// Two-master round-robin arbiter for one Avalon-MM burst read port.
// An in-order tag FIFO records {owner, beats} per accepted burst to steer returning data.
module dram_read_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 512,
    parameter int BURST_W  = 5,
    parameter int PEND_LOG = 3
) (
    input  logic                  clock,
    input  logic                  resetn,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic [BURST_W-1:0]    m0_burstcount,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic [BURST_W-1:0]    m1_burstcount,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,

    output logic [PEND_LOG:0]     pending,
    output logic                  err
);

    localparam int DEPTH = 1 << PEND_LOG;
    localparam logic [PEND_LOG:0] L_DEPTH = {1'b1, {PEND_LOG{1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   r_last;
    logic   w_owner_nxt;
    logic   w_last_nxt;
    logic   w_proto_err;

    logic [BURST_W:0]    r_fifo [DEPTH];
    logic [PEND_LOG-1:0] r_wr_ptr;
    logic [PEND_LOG-1:0] r_rd_ptr;
    logic [PEND_LOG:0]   r_pending;
    logic [BURST_W-1:0]  r_beat_cnt;
    logic                r_err;

    logic                w_full;
    logic                w_empty;
    logic                w_owner_read;
    logic [BURST_W-1:0]  w_owner_bc;
    logic                w_accept;
    logic [BURST_W-1:0]  w_push_bc;
    logic                w_head_owner;
    logic [BURST_W-1:0]  w_head_bc;
    logic                w_beat;
    logic [BURST_W-1:0]  w_remaining;
    logic                w_pop;

    assign w_full       = (r_pending == L_DEPTH);
    assign w_empty      = (r_pending == '0);
    assign w_owner_read = r_owner ? m1_read : m0_read;
    assign w_owner_bc   = r_owner ? m1_burstcount : m0_burstcount;

    assign avm_address    = r_owner ? m1_address : m0_address;
    assign avm_burstcount = w_owner_bc;
    assign avm_byteenable = '1;

    // Command-side handshake: a burst is accepted when avm_read is high and
    // avm_waitrequest is low in the same cycle; masters hold their command until then.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_proto_err    = 1'b0;
        avm_read       = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        w_accept       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_read && m1_read) begin
                    w_owner_nxt = ~r_last;
                    w_state_nxt = S_GRANT;
                end else if (m0_read) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = S_GRANT;
                end else if (m1_read) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                avm_read = w_owner_read & ~w_full;
                w_accept = avm_read & ~avm_waitrequest;
                if (r_owner) begin
                    m1_waitrequest = avm_waitrequest | w_full;
                end else begin
                    m0_waitrequest = avm_waitrequest | w_full;
                end
                if (w_accept) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = S_IDLE;
                end else if (!w_owner_read) begin
                    w_proto_err = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // A zero-length burst is tracked as a single beat so the return path stays aligned.
    assign w_push_bc = (w_owner_bc == '0) ? BURST_W'(1) : w_owner_bc;

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= {r_owner, w_push_bc};
        end
    end

    assign w_head_owner = r_fifo[r_rd_ptr][BURST_W];
    assign w_head_bc    = r_fifo[r_rd_ptr][BURST_W-1:0];
    assign w_beat       = avm_readdatavalid & ~w_empty;
    assign w_remaining  = (r_beat_cnt == '0) ? w_head_bc : r_beat_cnt;
    assign w_pop        = w_beat & (w_remaining == BURST_W'(1));

    assign m0_readdata      = avm_readdata;
    assign m1_readdata      = avm_readdata;
    assign m0_readdatavalid = w_beat & ~w_head_owner;
    assign m1_readdatavalid = w_beat & w_head_owner;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pending  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PEND_LOG'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PEND_LOG'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_pending <= r_pending + (PEND_LOG+1)'(1);
                2'b01:   r_pending <= r_pending - (PEND_LOG+1)'(1);
                default: r_pending <= r_pending;
            endcase
            if (w_beat) begin
                r_beat_cnt <= w_pop ? '0 : (w_remaining - BURST_W'(1));
            end
            if (w_proto_err || (avm_readdatavalid && w_empty) ||
                (w_accept && (w_owner_bc == '0))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pending = r_pending;
    assign err     = r_err;

endmodule
